ssc_scan_ctrl: RTL and testbench
================================

# ssc_scan_ctrl

Bus-master controller for the 32-channel spread-spectrum correlator register bank. Holds a per-channel configuration shadow (PN code, threshold), programs all 32 correlators after `start`, sets the global run bit, then polls the correlation-seen vector. For every newly set channel it reads back the result register in round-robin order and emits one event on a valid/ready stream. It sits between the host register file and the correlator bank's bus port.

## Interface
- `POLL_GAP`, default 16: idle cycles between consecutive polls of the seen vector (1..255).
- `BASE`, default 32'hFE000000: bank base address.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset rst, synchronous, active-high.
- `cfg_we`, in, 1: shadow write strobe; honoured only in IDLE.
- `cfg_idx`, in, 5: channel for a shadow write.
- `cfg_sel`, in, 1: 0 selects the code shadow, 1 selects the threshold shadow.
- `cfg_data`, in, 32: shadow write data.
- `start`, in, 1: one-cycle pulse; begins programming. Honoured only in IDLE.
- `stop`, in, 1: one-cycle pulse; aborts the run.
- `busy`, out, 1: high in every state except IDLE.
- `bus_addr`, out, 32: bank address.
- `bus_wdata`, out, 32: bank write data.
- `bus_write`, out, 1: single-cycle write.
- `bus_read`, out, 1: single-cycle read.
- `bus_rdata`, in, 32: bank read data, valid combinationally in the same cycle as `bus_read`.
- `evt_valid`, out, 1: event valid.
- `evt_ready`, in, 1: event accepted.
- `evt_idx`, out, 5: channel of the event.
- `evt_data`, out, 32: result word for that channel.
- `seen_mask`, out, 32: channels already reported in this run.

## Operation
- Address map, offsets from BASE:
  - 0x100: Run.
  - 0x108: CorrelationSeen, bit n = channel n.
  - 0x200+16n: code register of channel n.
  - 0x400+16n: threshold register of channel n.
  - 0x600+16n: result register of channel n.
- Shadow: two 32x32 arrays, code and threshold. Reset value 0. A write in IDLE updates the entry at `cfg_idx` selected by `cfg_sel`. Shadow writes outside IDLE are dropped.
- States and transitions:
  - IDLE -> PROG on `start`. Clears `seen_mask`, sets rr_ptr=0, sets ch=0.
  - PROG: 64 consecutive write cycles, alternating code[ch]@0x200+16ch then threshold[ch]@0x400+16ch, for ch=0..31 -> RUN_ON.
  - RUN_ON: one write, Wdata=1 @0x100 -> WAIT. Loads the gap counter with POLL_GAP.
  - WAIT: counter decrements each cycle; at 0 -> POLL.
  - POLL: one read @0x108. Compute new = rdata & ~seen_mask. If new==0 -> WAIT (counter reloaded). Otherwise latch new -> PICK.
  - PICK: one cycle. sel = first set bit of new at or above rr_ptr, searching circularly mod 32 -> RES.
  - RES: one read @0x600+16sel. Latch evt_data, evt_idx=sel. Set seen_mask[sel], clear new[sel], rr_ptr=(sel+1) mod 32 -> EMIT.
  - EMIT: `evt_valid`=1 and outputs are held stable until `evt_ready`. On acceptance: -> PICK if new!=0, else -> WAIT.
  - STOP: one write, Wdata=0 @0x100 -> IDLE.
- `stop` in any non-IDLE state goes to STOP on the next edge. It aborts PROG mid-sequence and drops a pending event (`evt_valid` falls, no acceptance). `stop` in IDLE is ignored.
- `start` and `stop` in the same cycle in IDLE: stop wins and the block stays IDLE.
- `start` while busy is ignored.
- Exactly one of `bus_write`/`bus_read` is high per bus cycle. Both are low in IDLE, WAIT, PICK and EMIT. `bus_addr`/`bus_wdata` are 0 whenever no strobe is active.

## Timing
- Reset values: every output is 0, shadow is 0, state is IDLE, rr_ptr=0, seen_mask=0.
- `start` at cycle T:
  - PROG writes occupy T+1..T+64.
  - Run write at T+65.
  - First poll at T+65+POLL_GAP+1.
- Latency from a poll with one new bit to `evt_valid`: 3 cycles (POLL, PICK, RES, then EMIT).
- Back-to-back events with `evt_ready` tied high: one event per 3 cycles.
- `rst` mid-operation returns to reset values immediately. No Run=0 write is issued on reset.

## Test plan
- Load code[n]=32'hA5000000+n and threshold[n]=n*4, then pulse start -> 64 writes in order: first 0xFE000200=A5000000, last 0xFE0007F0... corrected: last write 0xFE0005F0=124. Then 0xFE000100=1 at T+65.
- Bank returns seen=32'h0000_0011, results 0x600 and 0x640 → events (0, r0) then (4, r4). The next poll with the same vector produces no event.
- With rr_ptr=5 (channel 4 just serviced), seen=0x8000_0021 → event order 5, 31, 0.
- Hold `evt_ready` low for 10 cycles → `evt_valid`, `evt_idx` and `evt_data` stay stable, with no bus strobes. Releasing `evt_ready` produces the acceptance and the next transition.
- Pulse stop at PROG write 20 → next cycle writes 0xFE000100=0, then IDLE, `busy`=0, and no further writes.
- Assert `rst` during EMIT → the next cycle has all outputs 0 and state IDLE. A `cfg_we` while busy leaves the shadow unchanged (checked by a re-run).

Source files
------------

// File: rtl/ssc_scan_ctrl.sv
// Bus master for the 32-channel correlator bank: programs code/threshold shadows,
// starts the run, polls the seen vector and streams one event per newly seen channel.
module ssc_scan_ctrl #(
  parameter int          POLL_GAP = 16,
  parameter logic [31:0] BASE     = 32'hFE000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_idx,
  input  logic        cfg_sel,
  input  logic [31:0] cfg_data,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_write,
  output logic        bus_read,
  input  logic [31:0] bus_rdata,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [4:0]  evt_idx,
  output logic [31:0] evt_data,
  output logic [31:0] seen_mask,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PROG   = 4'd1;
  localparam logic [3:0] S_RUN_ON = 4'd2;
  localparam logic [3:0] S_WAIT   = 4'd3;
  localparam logic [3:0] S_POLL   = 4'd4;
  localparam logic [3:0] S_PICK   = 4'd5;
  localparam logic [3:0] S_RES    = 4'd6;
  localparam logic [3:0] S_EMIT   = 4'd7;
  localparam logic [3:0] S_STOP   = 4'd8;

  localparam logic [7:0] GAP = 8'(POLL_GAP);

  logic [3:0]  state_q, state_d;
  logic [5:0]  prog_cnt_q, prog_cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] seen_q, seen_d;
  logic [31:0] new_q, new_d;
  logic [4:0]  rr_q, rr_d;
  logic [4:0]  sel_q, sel_d;
  logic [4:0]  evt_idx_q, evt_idx_d;
  logic [31:0] evt_data_q, evt_data_d;
  logic [31:0] code_q [32];
  logic [31:0] code_d [32];
  logic [31:0] thr_q  [32];
  logic [31:0] thr_d  [32];

  logic [4:0]  prog_ch;
  logic [31:0] poll_new;
  logic [4:0]  pick_sel;
  logic [4:0]  pick_idx;
  logic        pick_found;

  assign prog_ch  = prog_cnt_q[5:1];
  assign poll_new = bus_rdata & ~seen_q;

  // First pending channel at or after rr_q, wrapping mod 32.
  always_comb begin
    pick_sel   = rr_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pick_idx = rr_q + 5'(i);
      if (!pick_found && new_q[pick_idx]) begin
        pick_sel   = pick_idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    prog_cnt_d = prog_cnt_q;
    gap_d      = gap_q;
    seen_d     = seen_q;
    new_d      = new_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    evt_idx_d  = evt_idx_q;
    evt_data_d = evt_data_q;
    code_d     = code_q;
    thr_d      = thr_q;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_write  = 1'b0;
    bus_read   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (cfg_sel) thr_d[cfg_idx]  = cfg_data;
          else         code_d[cfg_idx] = cfg_data;
        end
        if (start && !stop) begin
          state_d    = S_PROG;
          prog_cnt_d = '0;
          seen_d     = '0;
          new_d      = '0;
          rr_d       = '0;
        end
      end
      S_PROG: begin
        // Even counts write the code register, odd counts the threshold register.
        bus_write  = 1'b1;
        bus_addr   = BASE + (prog_cnt_q[0] ? 32'h400 : 32'h200) + {23'b0, prog_ch, 4'b0};
        bus_wdata  = prog_cnt_q[0] ? thr_q[prog_ch] : code_q[prog_ch];
        prog_cnt_d = prog_cnt_q + 6'd1;
        if (prog_cnt_q == 6'd63) state_d = S_RUN_ON;
      end
      S_RUN_ON: begin
        bus_write = 1'b1;
        bus_addr  = BASE + 32'h100;
        bus_wdata = 32'd1;
        gap_d     = GAP;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = S_POLL;
      end
      S_POLL: begin
        bus_read = 1'b1;
        bus_addr = BASE + 32'h108;
        if (poll_new == '0) begin
          gap_d   = GAP;
          state_d = S_WAIT;
        end else begin
          new_d   = poll_new;
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        sel_d   = pick_sel;
        state_d = S_RES;
      end
      S_RES: begin
        bus_read          = 1'b1;
        bus_addr          = BASE + 32'h600 + {23'b0, sel_q, 4'b0};
        evt_data_d        = bus_rdata;
        evt_idx_d         = sel_q;
        seen_d[sel_q]     = 1'b1;
        new_d[sel_q]      = 1'b0;
        rr_d              = sel_q + 5'd1;
        state_d           = S_EMIT;
      end
      S_EMIT: begin
        // Event is offered while in EMIT; it is consumed on a cycle with evt_valid && evt_ready.
        if (evt_ready) begin
          if (new_q != '0) begin
            state_d = S_PICK;
          end else begin
            gap_d   = GAP;
            state_d = S_WAIT;
          end
        end
      end
      S_STOP: begin
        bus_write = 1'b1;
        bus_addr  = BASE + 32'h100;
        bus_wdata = 32'd0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE) state_d = S_STOP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prog_cnt_q <= '0;
      gap_q      <= '0;
      seen_q     <= '0;
      new_q      <= '0;
      rr_q       <= '0;
      sel_q      <= '0;
      evt_idx_q  <= '0;
      evt_data_q <= '0;
      for (int i = 0; i < 32; i++) begin
        code_q[i] <= '0;
        thr_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      prog_cnt_q <= prog_cnt_d;
      gap_q      <= gap_d;
      seen_q     <= seen_d;
      new_q      <= new_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      evt_idx_q  <= evt_idx_d;
      evt_data_q <= evt_data_d;
      code_q     <= code_d;
      thr_q      <= thr_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign evt_valid = (state_q == S_EMIT);
  assign evt_idx   = evt_valid ? evt_idx_q  : 5'd0;
  assign evt_data  = evt_valid ? evt_data_q : 32'd0;
  assign seen_mask = seen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ssc_scan_ctrl.sv
// Bench for ssc_scan_ctrl: bank model, bus/event monitor with scoreboard,
// vector table for event ordering, directed timing sequences and a random phase.
module tb_ssc_scan_ctrl;

  localparam int          G    = 4;
  localparam logic [31:0] BASE = 32'hFE000000;

  logic        clk, rst;
  logic        cfg_we, cfg_sel, start, stop, evt_ready;
  logic [4:0]  cfg_idx;
  logic [31:0] cfg_data, bus_rdata;
  logic        busy, bus_write, bus_read, evt_valid;
  logic [31:0] bus_addr, bus_wdata, evt_data, seen_mask;
  logic [4:0]  evt_idx;
  logic [3:0]  dbg_state;

  ssc_scan_ctrl #(.POLL_GAP(G), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .start(start), .stop(stop), .busy(busy),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
    .bus_read(bus_read), .bus_rdata(bus_rdata), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_idx(evt_idx), .evt_data(evt_data),
    .seen_mask(seen_mask), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bank and reference model ----------------
  logic [31:0] bank_seen;
  logic [31:0] res_m  [32];
  logic [31:0] code_m [32];
  logic [31:0] thr_m  [32];
  logic [31:0] model_seen;
  int          model_rr;
  logic [31:0] rd_off;

  always_comb begin
    bus_rdata = '0;
    rd_off    = bus_addr - BASE - 32'h600;
    if (bus_read) begin
      if (bus_addr == BASE + 32'h108) bus_rdata = bank_seen;
      else if (bus_addr >= BASE + 32'h600 && bus_addr < BASE + 32'h800) bus_rdata = res_m[rd_off[8:4]];
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct { logic [31:0] cyc; logic [31:0] addr; logic [31:0] data; } bus_rec_t;
  bus_rec_t    wr_q[$];
  logic [36:0] exp_q[$];
  logic [4:0]  acc_q[$];
  int          rise_q[$];
  int          poll_q[$];
  int          hit_cyc;
  logic        prev_valid;
  logic        mon_en;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Each newly seen channel is reported once, in circular order from the channel after the last one served.
  task automatic model_poll(input logic [31:0] rd);
    logic [31:0] nw;
    logic        found;
    int          j;
    nw = rd & ~model_seen;
    if (nw != 0) hit_cyc = cyc;
    while (nw != 0) begin
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
        j = (model_rr + i) % 32;
        if (!found && nw[j]) begin
          found = 1'b1;
          exp_q.push_back({5'(j), res_m[j]});
          nw[j]         = 1'b0;
          model_seen[j] = 1'b1;
          model_rr      = (j + 1) % 32;
        end
      end
    end
  endtask

  task automatic on_accept();
    logic [36:0] e;
    acc_q.push_back(evt_idx);
    if (exp_q.size() == 0) check("evt_unexpected", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("evt_idx", 32'(evt_idx), 32'(e[36:32]));
      check("evt_data", evt_data, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("bus_both_strobes", 32'(bus_write & bus_read), 32'd0);
      if (!bus_write && !bus_read) begin
        check("idle_bus_addr", bus_addr, 32'd0);
        check("idle_bus_wdata", bus_wdata, 32'd0);
      end
      if (bus_write) wr_q.push_back('{32'(cyc), bus_addr, bus_wdata});
      if (bus_read && bus_addr == BASE + 32'h108) begin
        poll_q.push_back(cyc);
        model_poll(bus_rdata);
      end
      if (evt_valid && !prev_valid) rise_q.push_back(cyc);
      if (evt_valid && evt_ready) on_accept();
    end
    prev_valid <= evt_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bus_write"}, 32'(bus_write), 32'd0);
    check({tag, "_bus_read"}, 32'(bus_read), 32'd0);
    check({tag, "_bus_addr"}, bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_evt_idx"}, 32'(evt_idx), 32'd0);
    check({tag, "_evt_data"}, evt_data, 32'd0);
    check({tag, "_seen_mask"}, seen_mask, 32'd0);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic clear_model();
    model_seen = '0;
    model_rr   = 0;
    exp_q.delete();
  endtask

  task automatic cfg_write(input logic [4:0] idx, input logic sel, input logic [31:0] data, input bit taken);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
    if (taken) begin
      if (sel) thr_m[idx] = data;
      else     code_m[idx] = data;
    end
  endtask

  task automatic pulse_start(output int t);
    clear_model();
    wr_q.delete();
    poll_q.delete();
    t = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_polls(input int n);
    int p0, k;
    p0 = poll_q.size();
    k  = 0;
    while (poll_q.size() < p0 + n && k < 2000) begin tick(); k++; end
    if (poll_q.size() < p0 + n) check("poll_timeout", 32'(poll_q.size()), 32'(p0 + n));
    repeat (2) tick();
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!evt_valid && k < 500) begin tick(); k++; end
    if (!evt_valid) check("evt_valid_timeout", 32'd0, 32'd1);
  endtask

  // Checks the first n programming writes of a run started at cycle t against the shadow model.
  task automatic check_writes(input int t, input int n);
    bus_rec_t r;
    int k;
    k = 0;
    while (wr_q.size() < n && k < 200) begin tick(); k++; end
    for (int i = 0; i < n; i++) begin
      if (i >= wr_q.size()) begin
        check("prog_write_missing", 32'(i), 32'(n));
        break;
      end
      r = wr_q[i];
      check("prog_cyc", r.cyc, 32'(t + 1 + i));
      check("prog_addr", r.addr, BASE + ((i % 2) ? 32'h400 : 32'h200) + 32'(16 * (i / 2)));
      check("prog_data", r.data, (i % 2) ? thr_m[i / 2] : code_m[i / 2]);
    end
  endtask

  task automatic check_prog(input int t);
    check_writes(t, 64);
    wait_polls(1);
    check("run_write_count", 32'(wr_q.size()), 32'd65);
    if (wr_q.size() >= 65) begin
      check("run_write_cyc", wr_q[64].cyc, 32'(t + 65));
      check("run_write_addr", wr_q[64].addr, BASE + 32'h100);
      check("run_write_data", wr_q[64].data, 32'd1);
    end
    if (poll_q.size() > 0) check("first_poll_cyc", 32'(poll_q[0]), 32'(t + 65 + G + 1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          restart;
    logic [31:0] seen;
    int          n;
    logic [4:0]  e0, e1, e2;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [4:0] exp_at(input vec_t v, input int k);
    case (k)
      0:       return v.e0;
      1:       return v.e1;
      default: return v.e2;
    endcase
  endfunction

  int          t0;
  logic [4:0]  hold_idx;
  logic [31:0] hold_data;

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0011, 2, 5'd0, 5'd4, 5'd0};
    tbl[1] = '{1'b0, 32'h0000_0011, 0, 5'd0, 5'd0, 5'd0};
    tbl[2] = '{1'b1, 32'h0000_0010, 1, 5'd4, 5'd0, 5'd0};
    tbl[3] = '{1'b0, 32'h8000_0031, 3, 5'd5, 5'd31, 5'd0};
    tbl[4] = '{1'b0, 32'h8000_0331, 2, 5'd8, 5'd9, 5'd0};
    tbl[5] = '{1'b0, 32'hC000_0331, 1, 5'd30, 5'd0, 5'd0};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF, 25, 5'd1, 5'd2, 5'd3};

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = 1'b0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; evt_ready = 1'b1; bank_seen = '0;
    mon_en = 1'b0; hit_cyc = -1;
    for (int n = 0; n < 32; n++) begin
      res_m[n]  = 32'h5E00_0000 | 32'(n << 8) | 32'($urandom_range(0, 255));
      code_m[n] = '0;
      thr_m[n]  = '0;
    end
    clear_model();

    // reset state
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // start+stop together in IDLE, then stop alone in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    check("start_stop_busy", 32'(busy), 32'd0);
    pulse_stop();
    tick();
    check("idle_stop_busy", 32'(busy), 32'd0);
    check("idle_no_writes", 32'(wr_q.size()), 32'd0);

    // shadow load and full programming run
    for (int n = 0; n < 32; n++) begin
      cfg_write(5'(n), 1'b0, 32'hA500_0000 + 32'(n), 1'b1);
      cfg_write(5'(n), 1'b1, 32'(n * 4), 1'b1);
    end
    pulse_start(t0);
    check("busy_after_start", 32'(busy), 32'd1);
    check_prog(t0);

    // event ordering table, evt_ready held high
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].restart) begin
        pulse_stop();
        repeat (3) tick();
        bank_seen = '0;
        pulse_start(t0);
        wait_polls(1);
      end
      acc_q.delete();
      rise_q.delete();
      hit_cyc = -1;
      bank_seen = tbl[v].seen;
      wait_polls(2);
      check($sformatf("tbl%0d_count", v), 32'(acc_q.size()), 32'(tbl[v].n));
      for (int k = 0; k < 3 && k < tbl[v].n; k++) begin
        if (k < acc_q.size()) check($sformatf("tbl%0d_idx%0d", v, k), 32'(acc_q[k]), 32'(exp_at(tbl[v], k)));
        if (k < rise_q.size()) check($sformatf("tbl%0d_rise%0d", v, k), 32'(rise_q[k]), 32'(hit_cyc + 3 + 3 * k));
      end
      check($sformatf("tbl%0d_seen_mask", v), seen_mask, model_seen);
    end

    // shadow writes while busy must be dropped
    cfg_write(5'd3, 1'b0, 32'hDEAD_BEEF, 1'b0);
    cfg_write(5'd7, 1'b1, 32'hCAFE_F00D, 1'b0);
    pulse_stop();
    repeat (3) tick();

    // stop during the 20th programming write
    bank_seen = 32'h0000_0001;
    pulse_start(t0);
    while (cyc < t0 + 20) tick();
    pulse_stop();
    repeat (25) tick();
    check_writes(t0, 20);
    check("stop_write_count", 32'(wr_q.size()), 32'd21);
    if (wr_q.size() >= 21) begin
      check("stop_write_cyc", wr_q[20].cyc, 32'(t0 + 21));
      check("stop_write_addr", wr_q[20].addr, BASE + 32'h100);
      check("stop_write_data", wr_q[20].data, 32'd0);
    end
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_state_idle", 32'(dbg_state), 32'd0);
    check("stop_no_polls", 32'(poll_q.size()), 32'd0);

    // evt_ready held low: event and bus stay quiet and stable
    bank_seen = '0;
    pulse_start(t0);
    check_prog(t0);
    evt_ready = 1'b0;
    bank_seen = 32'h0000_1000;
    wait_valid();
    hold_idx  = evt_idx;
    hold_data = evt_data;
    check("hold_first_idx", 32'(hold_idx), 32'd12);
    check("hold_first_data", hold_data, res_m[12]);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_valid", 32'(evt_valid), 32'd1);
      check("hold_idx", 32'(evt_idx), 32'd12);
      check("hold_data", evt_data, res_m[12]);
      check("hold_no_write", 32'(bus_write), 32'd0);
      check("hold_no_read", 32'(bus_read), 32'd0);
    end
    evt_ready = 1'b1;
    tick();
    check("release_valid_low", 32'(evt_valid), 32'd0);
    check("release_exp_empty", 32'(exp_q.size()), 32'd0);
    check("release_seen_mask", seen_mask, 32'h0000_1000);

    // reset while an event is pending
    evt_ready = 1'b0;
    bank_seen = 32'h0000_1002;
    wait_valid();
    rst = 1'b1;
    tick();
    check_outputs_zero("rst_emit");
    rst = 1'b0;
    clear_model();
    for (int n = 0; n < 32; n++) begin
      code_m[n] = '0;
      thr_m[n]  = '0;
    end
    tick();

    // random phase: random shadow, random seen growth, random evt_ready
    for (int i = 0; i < 12; i++)
      cfg_write(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
    bank_seen = '0;
    pulse_start(t0);
    check_prog(t0);
    for (int i = 0; i < 400; i++) begin
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bank_seen = bank_seen | (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 31) == 0) bank_seen = bank_seen & ~(32'd1 << $urandom_range(0, 31));
      tick();
    end
    evt_ready = 1'b1;
    wait_polls(2);
    check("rand_exp_drained", 32'(exp_q.size()), 32'd0);
    check("rand_seen_mask", seen_mask, model_seen);
    pulse_stop();
    repeat (3) tick();
    check("rand_stop_busy", 32'(busy), 32'd0);
    if (wr_q.size() > 0) begin
      check("rand_stop_addr", wr_q[wr_q.size() - 1].addr, BASE + 32'h100);
      check("rand_stop_data", wr_q[wr_q.size() - 1].data, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
